axa_undo_stack: RTL and testbench

Parametrised undo stack for the AXA reversible pipeline. It replaces the hard-wired 16-entry, 4-bit-pointer `u` array and `usp` logic with a standalone block. It supports push on forward execution, pop on reverse execution, and relative-offset peek for undo-typed operands. The block sits beside the register-read stage: pushes and peeks issue from stage 2, and pops feed the ALU stage's restore path.

---
 rtl/axa_pkg.sv | 33 +++
 rtl/axa_undo_ram.sv | 55 +++++
 rtl/axa_undo_stack.sv | 144 ++++++++++++++
 tb/tb_axa_undo_stack.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/axa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : axa_pkg                                                     |
// | Brief  : Shared AXA constants: word width, undo-stack defaults and   |
// |          opcode encodings (bit 3 marks push-class opcodes).          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package axa_pkg;

    localparam int WORD       = 16;
    localparam int UNDO_DEPTH = 16;
    localparam int UNDO_PTR_W = $clog2(UNDO_DEPTH);

    // Opcodes with bit OP_PUSH_BIT set save their destination onto the undo stack.
    localparam int OP_PUSH_BIT = 3;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_XOR   = 4'h3,
        OP_ROL   = 4'h4,
        OP_PUSHI = 4'h8,
        OP_PUSHR = 4'h9,
        OP_SWAPU = 4'hA
    } axa_op_e;

    function automatic logic is_push_op(input logic [3:0] op);
        return op[OP_PUSH_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/axa_undo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : axa_undo_ram                                                |
// | Brief  : DEPTH x WIDTH undo storage, one synchronous write port and  |
// |          two registered read ports (pop with hold, peek every cycle).|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module axa_undo_ram
    import axa_pkg::*;
#(
    parameter  int WIDTH = WORD,
    parameter  int DEPTH = UNDO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop_re,
    input  logic [PTR_W-1:0] pop_addr,
    output logic [WIDTH-1:0] pop_rdata,
    input  logic [PTR_W-1:0] peek_addr,
    output logic [WIDTH-1:0] peek_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pop_rdata_q;
    logic [WIDTH-1:0] peek_rdata_q;

    // Storage write; contents are never reset or flushed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read registers sample the pre-write array, so a replace-top returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_rdata_q  <= '0;
            peek_rdata_q <= '0;
        end else begin
            if (pop_re) begin
                pop_rdata_q <= mem[pop_addr];
            end
            peek_rdata_q <= mem[peek_addr];
        end
    end

    assign pop_rdata  = pop_rdata_q;
    assign peek_rdata = peek_rdata_q;

endmodule
`default_nettype wire

// File: rtl/axa_undo_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : axa_undo_stack                                              |
// | Brief  : Parametrised undo stack: push, pop with 1-cycle return,     |
// |          replace-top on push+pop, relative peek, flush.              |
// |          Build option AXA_UNDO_STRICT_EN: refuse overflow and flag   |
// |          overflow/underflow on sticky err; otherwise wrap silently.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module axa_undo_stack
    import axa_pkg::*;
#(
    parameter  int WIDTH = WORD,
    parameter  int DEPTH = UNDO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    input  logic [PTR_W-1:0] peek_off,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_valid,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam logic [PTR_W-1:0] c_ONE   = 1;
    localparam logic [PTR_W:0]   c_DEPTH = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             err_q, err_d;
    logic             pop_valid_q, pop_valid_d;
    logic             peek_valid_q, peek_valid_d;

    logic             w_we;
    logic [PTR_W-1:0] w_waddr;
    logic             w_pop_re;
    logic [PTR_W-1:0] w_top;
    logic             w_has;
    logic             w_full;

    assign w_top  = sp_q - c_ONE;
    assign w_has  = (count_q != '0);
    assign w_full = (count_q == c_DEPTH);

    // Next-state for pointer, count and error plus RAM port control; flush beats push/pop.
    always_comb begin
        sp_d         = sp_q;
        count_d      = count_q;
        err_d        = err_q;
        pop_valid_d  = 1'b0;
        peek_valid_d = ({1'b0, peek_off} < count_q);
        w_we         = 1'b0;
        w_waddr      = sp_q;
        w_pop_re     = 1'b0;

        if (flush) begin
            sp_d    = '0;
            count_d = '0;
        end else if (push && pop && w_has) begin
            // Replace top: old top is returned, new word takes its slot.
            w_we        = 1'b1;
            w_waddr     = w_top;
            w_pop_re    = 1'b1;
            pop_valid_d = 1'b1;
        end else if (push) begin
`ifdef AXA_UNDO_STRICT_EN
            if (w_full) begin
                err_d = 1'b1;
            end else begin
                w_we    = 1'b1;
                sp_d    = sp_q + c_ONE;
                count_d = count_q + 1'b1;
            end
`else
            // When full the write lands on the oldest slot and count saturates.
            w_we    = 1'b1;
            sp_d    = sp_q + c_ONE;
            count_d = w_full ? count_q : count_q + 1'b1;
`endif
        end else if (pop) begin
            if (w_has) begin
                w_pop_re    = 1'b1;
                pop_valid_d = 1'b1;
                sp_d        = w_top;
                count_d     = count_q - 1'b1;
            end else begin
`ifdef AXA_UNDO_STRICT_EN
                err_d = 1'b1;
`endif
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q         <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            pop_valid_q  <= 1'b0;
            peek_valid_q <= 1'b0;
        end else begin
            sp_q         <= sp_d;
            count_q      <= count_d;
            err_q        <= err_d;
            pop_valid_q  <= pop_valid_d;
            peek_valid_q <= peek_valid_d;
        end
    end

    axa_undo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk        (clk),
        .reset      (reset),
        .we         (w_we),
        .waddr      (w_waddr),
        .wdata      (push_data),
        .pop_re     (w_pop_re),
        .pop_addr   (w_top),
        .pop_rdata  (pop_data),
        .peek_addr  (w_top - peek_off),
        .peek_rdata (peek_data)
    );

    assign pop_valid  = pop_valid_q;
    assign peek_valid = peek_valid_q;
    assign count      = count_q;
    assign empty      = !w_has;
    assign full       = w_full;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axa_undo_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_axa_undo_stack                                           |
// | Brief  : Self-checking bench for axa_undo_stack (DEPTH=16, WIDTH=16);|
// |          expectations follow the AXA_UNDO_STRICT_EN build option.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_axa_undo_stack;

`ifdef AXA_UNDO_STRICT_EN
    localparam logic c_STRICT = 1'b1;
`else
    localparam logic c_STRICT = 1'b0;
`endif

    typedef struct {
        logic        flush;
        logic        push;
        logic        pop;
        logic [15:0] pd;
        logic [3:0]  off;
        logic        exp_pv;
        logic [15:0] exp_pdata;
        logic        exp_kv;
        logic [15:0] exp_kdata;
        logic [4:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush, push, pop;
    logic [15:0] push_data;
    logic [3:0]  peek_off;
    logic [15:0] pop_data, peek_data;
    logic        pop_valid, peek_valid, empty, full, err;
    logic [4:0]  count;

    int errors = 0;
    int checks = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    axa_undo_stack dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .peek_off   (peek_off),
        .peek_data  (peek_data),
        .peek_valid (peek_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .err        (err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic fl, input logic pu, input logic po, input logic [15:0] pd,
                       input logic [3:0] off, input logic pv, input logic [15:0] pdat,
                       input logic kv, input logic [15:0] kdat, input logic [4:0] cnt,
                       input logic e);
        vec_t v;
        v = '{fl, pu, po, pd, off, pv, pdat, kv, kdat, cnt, e};
        tbl.push_back(v);
    endtask

    task automatic compare(input vec_t v);
        chk("pop_valid",  {15'd0, pop_valid}, {15'd0, v.exp_pv});
        chk("pop_data",   pop_data, v.exp_pdata);
        chk("peek_valid", {15'd0, peek_valid}, {15'd0, v.exp_kv});
        if (v.exp_kv) chk("peek_data", peek_data, v.exp_kdata);
        chk("count", {11'd0, count}, {11'd0, v.exp_cnt});
        chk("empty", {15'd0, empty}, {15'd0, (v.exp_cnt == 5'd0)});
        chk("full",  {15'd0, full},  {15'd0, (v.exp_cnt == 5'd16)});
        chk("err",   {15'd0, err},   {15'd0, v.exp_err});
    endtask

    // Drive one cycle, queue its expectation, then retire it after the edge.
    task automatic step(input vec_t v);
        flush     = v.flush;
        push      = v.push;
        pop       = v.pop;
        push_data = v.pd;
        peek_off  = v.off;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        compare(exp_q.pop_front());
    endtask

    task automatic do_reset(input logic with_traffic);
        reset     = 1'b1;
        flush     = 1'b0;
        push      = with_traffic;
        pop       = with_traffic;
        push_data = 16'hDEAD;
        peek_off  = '0;
        @(posedge clk);
        #1;
        chk("rst pop_data",   pop_data, 16'h0);
        chk("rst pop_valid",  {15'd0, pop_valid}, 16'h0);
        chk("rst peek_data",  peek_data, 16'h0);
        chk("rst peek_valid", {15'd0, peek_valid}, 16'h0);
        chk("rst count",      {11'd0, count}, 16'h0);
        chk("rst empty",      {15'd0, empty}, 16'h1);
        chk("rst full",       {15'd0, full}, 16'h0);
        chk("rst err",        {15'd0, err}, 16'h0);
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic e;
        e = c_STRICT;

        // fl pu po data    off pv pdata    kv kdata    cnt  err
        add(0, 1, 0, 16'h1111, 0, 0, 16'h0000, 0, 16'h0000, 1, 0);
        add(0, 1, 0, 16'h2222, 0, 0, 16'h0000, 1, 16'h1111, 2, 0);
        add(0, 1, 0, 16'h3333, 0, 0, 16'h0000, 1, 16'h2222, 3, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3333, 3, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h2222, 3, 0);
        add(0, 0, 0, 16'h0000, 2, 0, 16'h0000, 1, 16'h1111, 3, 0);
        add(0, 0, 0, 16'h0000, 3, 0, 16'h0000, 0, 16'h0000, 3, 0);
        add(0, 0, 1, 16'h0000, 0, 1, 16'h3333, 1, 16'h3333, 2, 0);
        add(0, 0, 1, 16'h0000, 0, 1, 16'h2222, 1, 16'h2222, 1, 0);
        add(0, 0, 1, 16'h0000, 0, 1, 16'h1111, 1, 16'h1111, 0, 0);
        add(0, 0, 1, 16'h0000, 0, 0, 16'h1111, 0, 16'h0000, 0, e);
        add(0, 1, 0, 16'hAAAA, 0, 0, 16'h1111, 0, 16'h0000, 1, e);
        add(0, 1, 1, 16'hBBBB, 0, 1, 16'hAAAA, 1, 16'hAAAA, 1, e);
        add(0, 0, 0, 16'h0000, 0, 0, 16'hAAAA, 1, 16'hBBBB, 1, e);
        add(0, 1, 0, 16'h0101, 0, 0, 16'hAAAA, 1, 16'hBBBB, 2, e);
        add(0, 1, 0, 16'h0102, 0, 0, 16'hAAAA, 1, 16'h0101, 3, e);
        add(0, 1, 0, 16'h0103, 0, 0, 16'hAAAA, 1, 16'h0102, 4, e);
        add(0, 1, 0, 16'h0104, 0, 0, 16'hAAAA, 1, 16'h0103, 5, e);
        add(0, 1, 0, 16'h0105, 0, 0, 16'hAAAA, 1, 16'h0104, 6, e);
        add(1, 1, 0, 16'h0F0F, 0, 0, 16'hAAAA, 1, 16'h0105, 0, e);
        add(0, 0, 0, 16'h0000, 0, 0, 16'hAAAA, 0, 16'h0000, 0, e);

        reset = 1'b1; flush = 0; push = 0; pop = 0; push_data = 0; peek_off = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Overflow: push 1..17 into a 16-deep stack.
        do_reset(1'b0);
        for (int i = 1; i <= 17; i++) begin
            v = '{0, 1, 0, 16'(i), 4'd0, 0, 16'h0, (i > 1), 16'(i - 1),
                  (i > 16) ? 5'd16 : 5'(i), (i == 17) ? e : 1'b0};
            step(v);
        end
        v = '{0, 0, 0, 16'h0, 4'd0, 0, 16'h0, 1, c_STRICT ? 16'd16 : 16'd17, 5'd16, e};
        step(v);
        v = '{0, 0, 0, 16'h0, 4'd15, 0, 16'h0, 1, c_STRICT ? 16'd1 : 16'd2, 5'd16, e};
        step(v);
        // Replace top while full is always legal.
        v = '{0, 1, 1, 16'h7777, 4'd0, 1, c_STRICT ? 16'd16 : 16'd17, 1,
              c_STRICT ? 16'd16 : 16'd17, 5'd16, e};
        step(v);
        v = '{0, 0, 0, 16'h0, 4'd0, 0, c_STRICT ? 16'd16 : 16'd17, 1, 16'h7777, 5'd16, e};
        step(v);

        // Reset in the same cycle as push+pop drops everything.
        do_reset(1'b0);
        v = '{0, 1, 0, 16'h4444, 4'd0, 0, 16'h0, 0, 16'h0, 5'd1, 0};
        step(v);
        v = '{0, 1, 0, 16'h5555, 4'd0, 0, 16'h0, 1, 16'h4444, 5'd2, 0};
        step(v);
        do_reset(1'b1);
        v = '{0, 0, 0, 16'h0, 4'd0, 0, 16'h0, 0, 16'h0, 5'd0, 0};
        step(v);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
